mc_control_fsm: RTL and testbench

Multi-cycle MIPS main control unit. It sequences every instruction through fetch, decode, execute, memory and writeback states. It drives the PC update controls (`pc_src`, `pc_en`), the memory/IR/register-file enables and the ALU operand selects. It sits between the instruction register opcode field and the PC, memory, register file and ALU-control blocks of the Nexys3 multi-cycle datapath.

---
 rtl/mc_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Define MC_INSTR_COUNT_EN to build the 32-bit retired-instruction counter.
`timescale 1ns/1ps
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  pc_src,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t state, state_nxt;

  // Raw strobes before the reset gate.
  logic pc_write, branch, ir_load, mem_wr_raw, reg_wr_raw, illegal_raw;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: is_supported = 1'b1;
      default:                                       is_supported = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:  state_nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_nxt = MEMWB;
      MEMWB:   state_nxt = FETCH;
      MEMWR:   if (mem_ready) state_nxt = FETCH;
      EXECUTE: state_nxt = ALUWB;
      ALUWB:   state_nxt = FETCH;
      BRANCH:  state_nxt = FETCH;
      ADDIEX:  state_nxt = ADDIWB;
      ADDIWB:  state_nxt = FETCH;
      JUMP:    state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_src      = 2'b00;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_write    = 1'b0;
    branch      = 1'b0;
    ir_load     = 1'b0;
    mem_wr_raw  = 1'b0;
    reg_wr_raw  = 1'b0;
    illegal_raw = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_load   = mem_ready;
      end
      DECODE: begin
        alu_src_b   = 2'b11;
        illegal_raw = !is_supported(opcode);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr_raw = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mem_wr_raw = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_wr_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB:  reg_wr_raw = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset suppresses every strobe so an interrupted instruction has no side effects.
  assign pc_en      = !reset && (pc_write || (branch && zero));
  assign ir_write   = !reset && ir_load;
  assign mem_write  = !reset && mem_wr_raw;
  assign reg_write  = !reset && reg_wr_raw;
  assign illegal_op = !reset && illegal_raw;

`ifdef MC_INSTR_COUNT_EN
  logic retire;

  // An instruction retires on its final transition back into FETCH.
  always_comb begin
    case (state)
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
      MEMWR:                              retire = mem_ready;
      default:                            retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       instr_count <= 32'd0;
    else if (retire) instr_count <= instr_count + 32'd1;
  end
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: vector table, directed corner sequences,
// and randomized traffic against an instruction-level step-list model.
`timescale 1ns/1ps
module tb_mc_control_fsm;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

`ifdef MC_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Layout: pc_src(2) pc_en iord mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b(2) alu_op(2) illegal_op
  localparam logic [14:0] F_IDLE = 15'b00_0_0_0_0_0_0_0_0_01_00_0;
  localparam logic [14:0] F_RUN  = 15'b00_1_0_0_1_0_0_0_0_01_00_0;
  localparam logic [14:0] D_OK   = 15'b00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [14:0] D_ILL  = 15'b00_0_0_0_0_0_0_0_0_11_00_1;
  localparam logic [14:0] V_MA   = 15'b00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [14:0] V_MR   = 15'b00_0_1_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] V_MWB  = 15'b00_0_0_0_0_0_1_1_0_00_00_0;
  localparam logic [14:0] V_MWR  = 15'b00_0_1_1_0_0_0_0_0_00_00_0;
  localparam logic [14:0] V_EX   = 15'b00_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [14:0] AWB_R  = 15'b00_0_0_0_0_1_0_0_0_00_00_0;
  localparam logic [14:0] BR_T   = 15'b01_1_0_0_0_0_0_0_1_00_01_0;
  localparam logic [14:0] BR_N   = 15'b01_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [14:0] V_AX   = 15'b00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [14:0] V_AIWB = 15'b00_0_0_0_0_0_0_1_0_00_00_0;
  localparam logic [14:0] V_J    = 15'b10_1_0_0_0_0_0_0_0_00_00_0;

  typedef enum {K_F, K_D, K_MA, K_MR, K_MWB, K_MWR, K_EX, K_AWB, K_BR, K_AX, K_AIWB, K_J} kind_t;
  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [14:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, zero, mem_ready;
  logic [5:0]  opcode;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a, illegal_op;
  logic [31:0] instr_count;
  logic [14:0] act;

  int checks = 0;
  int failures = 0;

  kind_t       q[$];
  logic [5:0]  prog[$];
  logic [5:0]  cur_op = OP_R;
  bit          cur_ill = 1'b0;
  logic [31:0] mcnt = 32'd0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  assign act = {pc_src, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, check outputs at the falling edge, leave just after the next rise.
  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                      input logic [14:0] exp, input string name);
    reset = r; opcode = op; zero = z; mem_ready = mr;
    @(negedge clk);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: outputs got %b required %b", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input logic [31:0] n, input string name);
    logic [31:0] want;
    want = CNT_EN ? n : 32'd0;
    checks++;
    if (instr_count !== want) begin
      failures++;
      $display("FAIL %s: instr_count got %0d required %0d", name, instr_count, want);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  // Output bundle for one step of an instruction, straight from the per-state table.
  function automatic logic [14:0] model_out(input kind_t k, input logic r, input logic [5:0] op,
                                            input logic z, input logic mr);
    logic [1:0] ps, asb, aop;
    logic pe, io, mw, irw, rd, m2r, rw, asa, ill;
    {ps, asb, aop} = '0;
    {pe, io, mw, irw, rd, m2r, rw, asa, ill} = '0;
    case (k)
      K_F:    begin asb = 2'b01; pe = mr; irw = mr; end
      K_D:    begin asb = 2'b11; ill = !legal(op); end
      K_MA:   begin asa = 1'b1; asb = 2'b10; end
      K_MR:   io = 1'b1;
      K_MWB:  begin m2r = 1'b1; rw = 1'b1; end
      K_MWR:  begin io = 1'b1; mw = 1'b1; end
      K_EX:   begin asa = 1'b1; aop = 2'b10; end
      K_AWB:  begin rd = 1'b1; rw = 1'b1; end
      K_BR:   begin asa = 1'b1; aop = 2'b01; ps = 2'b01; pe = z; end
      K_AX:   begin asa = 1'b1; asb = 2'b10; end
      K_AIWB: rw = 1'b1;
      K_J:    begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    if (r) {pe, irw, mw, rw, ill} = '0;
    return {ps, pe, io, mw, irw, rd, m2r, rw, asa, asb, aop, ill};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[10];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'b111111, 6'b000001, 6'b100000, 6'b001001};
    return ops[$urandom_range(0, 9)];
  endfunction

  task automatic load_instr(input logic [5:0] op);
    q = '{K_F, K_D};
    cur_ill = 1'b0;
    case (op)
      OP_R:    begin q.push_back(K_EX); q.push_back(K_AWB); end
      OP_LW:   begin q.push_back(K_MA); q.push_back(K_MR); q.push_back(K_MWB); end
      OP_SW:   begin q.push_back(K_MA); q.push_back(K_MWR); end
      OP_BEQ:  q.push_back(K_BR);
      OP_ADDI: begin q.push_back(K_AX); q.push_back(K_AIWB); end
      OP_J:    q.push_back(K_J);
      default: cur_ill = 1'b1;
    endcase
  endtask

  // One model-checked cycle: memory waits repeat a step, reset abandons the instruction.
  task automatic mcycle(input logic r, input logic mr, input logic z);
    kind_t k;
    if (q.size() == 0) begin
      cur_op = (prog.size() > 0) ? prog.pop_front() : pick_op();
      load_instr(cur_op);
    end
    k = q[0];
    step(r, cur_op, z, mr, model_out(k, r, cur_op, z, mr), $sformatf("model_%s_op%b", k.name(), cur_op));
    if (r) begin
      q.delete();
      mcnt = 32'd0;
    end else if (!(k inside {K_F, K_MR, K_MWR}) || mr) begin
      void'(q.pop_front());
      if (q.size() == 0 && !cur_ill) mcnt = mcnt + 32'd1;
    end
    check_cnt(mcnt, "model_count");
  endtask

  vec_t tbl[7];

  initial begin
    reset = 1'b1; opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    tbl[0] = '{1'b1, OP_LW, 1'b0, 1'b1, F_IDLE};
    tbl[1] = '{1'b1, OP_LW, 1'b0, 1'b1, F_IDLE};
    tbl[2] = '{1'b0, OP_LW, 1'b0, 1'b1, F_RUN};
    tbl[3] = '{1'b0, OP_LW, 1'b0, 1'b1, D_OK};
    tbl[4] = '{1'b0, OP_LW, 1'b0, 1'b1, V_MA};
    tbl[5] = '{1'b0, OP_LW, 1'b0, 1'b1, V_MR};
    tbl[6] = '{1'b0, OP_LW, 1'b0, 1'b1, V_MWB};
    @(posedge clk);
    #1;
    check_cnt(32'd0, "reset_count");
    for (int i = 0; i < 7; i++)
      step(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].exp, $sformatf("lw_table%0d", i));
    check_cnt(32'd1, "lw_count");

    // beq taken and not taken
    step(1'b0, OP_BEQ, 1'b1, 1'b1, F_RUN, "beq_t_fetch");
    step(1'b0, OP_BEQ, 1'b1, 1'b1, D_OK,  "beq_t_decode");
    step(1'b0, OP_BEQ, 1'b1, 1'b1, BR_T,  "beq_t_branch");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, F_RUN, "beq_n_fetch");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, D_OK,  "beq_n_decode");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, BR_N,  "beq_n_branch");
    check_cnt(32'd3, "beq_count");

    // sw with three wait cycles in MEMWR
    step(1'b0, OP_SW, 1'b0, 1'b1, F_RUN, "sw_fetch");
    step(1'b0, OP_SW, 1'b0, 1'b1, D_OK,  "sw_decode");
    step(1'b0, OP_SW, 1'b0, 1'b0, V_MA,  "sw_memadr_ignores_ready");
    for (int i = 0; i < 3; i++)
      step(1'b0, OP_SW, 1'b0, 1'b0, V_MWR, $sformatf("sw_wait%0d", i));
    step(1'b0, OP_SW, 1'b0, 1'b1, V_MWR, "sw_done");
    check_cnt(32'd4, "sw_count");

    // jump, then an illegal opcode, then addi
    step(1'b0, OP_J, 1'b0, 1'b1, F_RUN, "j_fetch");
    step(1'b0, OP_J, 1'b0, 1'b1, D_OK,  "j_decode");
    step(1'b0, OP_J, 1'b0, 1'b1, V_J,   "j_jump");
    step(1'b0, OP_BAD, 1'b0, 1'b1, F_RUN, "ill_fetch");
    step(1'b0, OP_BAD, 1'b0, 1'b1, D_ILL, "ill_decode");
    check_cnt(32'd5, "ill_count_unchanged");
    step(1'b0, OP_ADDI, 1'b0, 1'b1, F_RUN,  "addi_fetch");
    step(1'b0, OP_ADDI, 1'b0, 1'b1, D_OK,   "addi_decode");
    step(1'b0, OP_ADDI, 1'b0, 1'b1, V_AX,   "addi_ex");
    step(1'b0, OP_ADDI, 1'b0, 1'b1, V_AIWB, "addi_wb");
    check_cnt(32'd6, "addi_count");

    // reset landing in ALUWB of an R-type
    step(1'b0, OP_R, 1'b0, 1'b1, F_RUN, "rrst_fetch");
    step(1'b0, OP_R, 1'b0, 1'b1, D_OK,  "rrst_decode");
    step(1'b0, OP_R, 1'b0, 1'b1, V_EX,  "rrst_execute");
    step(1'b1, OP_R, 1'b0, 1'b1, AWB_R, "rrst_aluwb_in_reset");
    check_cnt(32'd0, "rrst_count");
    step(1'b0, OP_R, 1'b0, 1'b0, F_IDLE, "rrst_fetch_after");

    // back-to-back program through the model
    q.delete();
    mcnt = 32'd0;
    prog = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    for (int i = 0; i < 100 && (prog.size() > 0 || q.size() > 0); i++)
      mcycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    checks++;
    if (prog.size() != 0 || q.size() != 0) begin
      failures++;
      $display("FAIL b2b_bound: program left %0d instrs, required 0", prog.size() + q.size());
    end
    check_cnt(32'd6, "b2b_count");

    // randomized traffic with stalls and occasional reset
    for (int i = 0; i < 3000; i++)
      mcycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
